// File: rtl/branch_resolve_ctrl.sv
// Branch resolve controller: tracks unresolved branches, throttles issue,
// and sequences mispredict recovery (held redirect, then one-cycle squash).
module branch_resolve_ctrl #(
  parameter int NR_UNRESOLVED = 4,
  parameter int CNT_W = $clog2(NR_UNRESOLVED + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             debug_mode_i,
  input  logic             issue_branch_i,
  output logic             issue_ready_o,
  input  logic             resolve_valid_i,
  input  logic             resolve_mispredict_i,
  input  logic [63:0]      resolve_target_i,
  output logic             redirect_valid_o,
  output logic [63:0]      redirect_pc_o,
  input  logic             redirect_ready_i,
  output logic             squash_o,
  output logic [CNT_W-1:0] outstanding_o,
  output logic             resolve_err_o,
  output logic [31:0]      mispredict_cnt_o
);

  typedef enum logic [1:0] {
    IDLE,
    REDIRECT,
    SQUASH
  } state_e;

  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(NR_UNRESOLVED);

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_rvalid;
  logic [63:0]      r_rpc;
  logic             r_squash;
  logic             r_err;
  logic [31:0]      r_mcnt;

  logic w_idle;
  logic w_full;
  logic w_hs;
  logic w_dec;
  logic w_mis;
  logic w_zero;

  assign w_idle = (r_state == IDLE);
  assign w_full = (r_cnt >= MaxCnt);
  assign w_zero = (r_cnt == '0);
  assign w_mis  = resolve_valid_i & resolve_mispredict_i;

  // At full, a correct resolve in the same cycle frees a slot for the issue.
  assign issue_ready_o = w_idle &
    (!w_full | (resolve_valid_i & !resolve_mispredict_i));

  assign w_hs  = issue_branch_i & issue_ready_o;
  assign w_dec = resolve_valid_i & !w_zero;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_rvalid <= 1'b0;
      r_rpc    <= '0;
      r_squash <= 1'b0;
      r_err    <= 1'b0;
      r_mcnt   <= '0;
    end else if (flush_i) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_rvalid <= 1'b0;
      r_squash <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_squash <= 1'b0;
          r_err    <= resolve_valid_i & w_zero;
          if (w_mis) begin
            // The same-cycle issue is younger and will be squashed.
            r_cnt    <= r_cnt - CNT_W'(w_dec);
            r_rpc    <= resolve_target_i;
            r_rvalid <= 1'b1;
            r_state  <= REDIRECT;
            if (!debug_mode_i) r_mcnt <= r_mcnt + 32'd1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(w_hs) - CNT_W'(w_dec);
          end
        end
        REDIRECT: begin
          r_err    <= 1'b0;
          r_squash <= 1'b0;
          if (redirect_ready_i) begin
            r_rvalid <= 1'b0;
            r_squash <= 1'b1;
            r_cnt    <= '0;
            r_state  <= SQUASH;
          end
        end
        SQUASH: begin
          r_err    <= 1'b0;
          r_squash <= 1'b0;
          r_cnt    <= '0;
          r_state  <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign redirect_valid_o = r_rvalid;
  assign redirect_pc_o    = r_rpc;
  assign squash_o         = r_squash;
  assign outstanding_o    = r_cnt;
  assign resolve_err_o    = r_err;
  assign mispredict_cnt_o = r_mcnt;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl with an expected-value queue.
module tb_branch_resolve_ctrl;

  localparam int N = 4;
  localparam int CW = $clog2(N + 1);

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          flush_i;
  logic          debug_mode_i;
  logic          issue_branch_i;
  logic          issue_ready_o;
  logic          resolve_valid_i;
  logic          resolve_mispredict_i;
  logic [63:0]   resolve_target_i;
  logic          redirect_valid_o;
  logic [63:0]   redirect_pc_o;
  logic          redirect_ready_i;
  logic          squash_o;
  logic [CW-1:0] outstanding_o;
  logic          resolve_err_o;
  logic [31:0]   mispredict_cnt_o;

  typedef struct {
    string       tag;
    logic [63:0] v;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  branch_resolve_ctrl #(.NR_UNRESOLVED(N)) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .flush_i(flush_i),
    .debug_mode_i(debug_mode_i),
    .issue_branch_i(issue_branch_i),
    .issue_ready_o(issue_ready_o),
    .resolve_valid_i(resolve_valid_i),
    .resolve_mispredict_i(resolve_mispredict_i),
    .resolve_target_i(resolve_target_i),
    .redirect_valid_o(redirect_valid_o),
    .redirect_pc_o(redirect_pc_o),
    .redirect_ready_i(redirect_ready_i),
    .squash_o(squash_o),
    .outstanding_o(outstanding_o),
    .resolve_err_o(resolve_err_o),
    .mispredict_cnt_o(mispredict_cnt_o)
  );

  task automatic push(input string tag, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [63:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL sb_empty got %0h", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.v) else begin
        errors++;
        $error("FAIL %s got %0h exp %0h", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_ni = 1'b0;
    flush_i = 1'b0;
    debug_mode_i = 1'b0;
    issue_branch_i = 1'b0;
    resolve_valid_i = 1'b0;
    resolve_mispredict_i = 1'b0;
    resolve_target_i = '0;
    redirect_ready_i = 1'b0;
    #3;
    push("rst_cnt", 0);    chk(64'(outstanding_o));
    push("rst_rdy", 1);    chk(64'(issue_ready_o));
    push("rst_rv", 0);     chk(64'(redirect_valid_o));
    push("rst_pc", 0);     chk(redirect_pc_o);
    push("rst_sq", 0);     chk(64'(squash_o));
    push("rst_err", 0);    chk(64'(resolve_err_o));
    push("rst_mcnt", 0);   chk(64'(mispredict_cnt_o));
    #4 rst_ni = 1'b1;
    step();

    // fill to the budget
    issue_branch_i = 1'b1;
    for (int i = 1; i <= N; i++) begin
      push("fill_cnt", 64'(i));
      step();
      chk(64'(outstanding_o));
    end
    push("full_rdy", 0);   chk(64'(issue_ready_o));
    push("blk_cnt", N);
    step();
    chk(64'(outstanding_o));

    // full + resolve + issue in the same cycle
    resolve_valid_i = 1'b1;
    #1;
    push("full_rdy_res", 1); chk(64'(issue_ready_o));
    push("full_both", N);
    step();
    chk(64'(outstanding_o));

    issue_branch_i = 1'b0;
    step();
    push("dec_cnt", 2);
    step();
    chk(64'(outstanding_o));

    // mispredict with delayed redirect acceptance
    resolve_mispredict_i = 1'b1;
    resolve_target_i = 64'h8000_0040;
    push("mp_rv", 1);
    push("mp_pc", 64'h8000_0040);
    push("mp_cnt", 1);
    push("mp_mcnt", 1);
    step();
    chk(64'(redirect_valid_o));
    chk(redirect_pc_o);
    chk(64'(outstanding_o));
    chk(64'(mispredict_cnt_o));
    resolve_valid_i = 1'b0;
    resolve_mispredict_i = 1'b0;
    push("hold_rdy", 0);   chk(64'(issue_ready_o));
    // younger mispredict inside REDIRECT is ignored
    resolve_valid_i = 1'b1;
    resolve_mispredict_i = 1'b1;
    resolve_target_i = 64'hdead_beef;
    push("ign_rv", 1);
    push("ign_pc", 64'h8000_0040);
    push("ign_mcnt", 1);
    push("ign_cnt", 1);
    push("ign_err", 0);
    step();
    chk(64'(redirect_valid_o));
    chk(redirect_pc_o);
    chk(64'(mispredict_cnt_o));
    chk(64'(outstanding_o));
    chk(64'(resolve_err_o));
    resolve_valid_i = 1'b0;
    resolve_mispredict_i = 1'b0;
    push("hold3_rv", 1);
    push("hold3_pc", 64'h8000_0040);
    step();
    chk(64'(redirect_valid_o));
    chk(redirect_pc_o);
    redirect_ready_i = 1'b1;
    push("sq_rv", 0);
    push("sq_pulse", 1);
    push("sq_cnt", 0);
    push("sq_rdy", 0);
    step();
    chk(64'(redirect_valid_o));
    chk(64'(squash_o));
    chk(64'(outstanding_o));
    chk(64'(issue_ready_o));
    redirect_ready_i = 1'b0;
    push("post_sq", 0);
    push("post_rdy", 1);
    push("post_mcnt", 1);
    step();
    chk(64'(squash_o));
    chk(64'(issue_ready_o));
    chk(64'(mispredict_cnt_o));

    // underflow
    resolve_valid_i = 1'b1;
    push("uf_err", 1);
    push("uf_cnt", 0);
    step();
    chk(64'(resolve_err_o));
    chk(64'(outstanding_o));
    resolve_valid_i = 1'b0;
    push("uf_err_end", 0);
    step();
    chk(64'(resolve_err_o));

    // underflow mispredict still redirects; then flush kills it
    resolve_valid_i = 1'b1;
    resolve_mispredict_i = 1'b1;
    resolve_target_i = 64'h1234;
    push("ufm_rv", 1);
    push("ufm_err", 1);
    push("ufm_mcnt", 2);
    step();
    chk(64'(redirect_valid_o));
    chk(64'(resolve_err_o));
    chk(64'(mispredict_cnt_o));
    resolve_valid_i = 1'b0;
    resolve_mispredict_i = 1'b0;
    flush_i = 1'b1;
    redirect_ready_i = 1'b1;
    push("fl_rv", 0);
    push("fl_sq", 0);
    push("fl_cnt", 0);
    step();
    chk(64'(redirect_valid_o));
    chk(64'(squash_o));
    chk(64'(outstanding_o));
    flush_i = 1'b0;
    redirect_ready_i = 1'b0;
    push("fl_rdy", 1);
    push("fl_sq2", 0);
    push("fl_mcnt", 2);
    step();
    chk(64'(issue_ready_o));
    chk(64'(squash_o));
    chk(64'(mispredict_cnt_o));

    // debug mode freezes the perf counter
    debug_mode_i = 1'b1;
    issue_branch_i = 1'b1;
    push("dbg_cnt", 1);
    step();
    chk(64'(outstanding_o));
    issue_branch_i = 1'b0;
    resolve_valid_i = 1'b1;
    resolve_mispredict_i = 1'b1;
    resolve_target_i = 64'h40;
    push("dbg_rv", 1);
    push("dbg_mcnt", 2);
    step();
    chk(64'(redirect_valid_o));
    chk(64'(mispredict_cnt_o));
    resolve_valid_i = 1'b0;
    resolve_mispredict_i = 1'b0;

    // async reset in the middle of REDIRECT
    #2 rst_ni = 1'b0;
    #1;
    push("ar_rv", 0);
    push("ar_pc", 0);
    push("ar_mcnt", 0);
    push("ar_rdy", 1);
    chk(64'(redirect_valid_o));
    chk(redirect_pc_o);
    chk(64'(mispredict_cnt_o));
    chk(64'(issue_ready_o));
    #2 rst_ni = 1'b1;
    step();

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL sb_left got %0d exp 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
